// File: rtl/psg_bus_control_if.sv
// rtl/psg_bus_control_if.sv - PSG bus pin bundle (BDIR/BC1 control, data in/out, output enable)
interface psg_bus_control_if;
  logic       bdir;
  logic       bc1;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (output bdir, output bc1, output data_in, input data_out, input data_oe);
  modport slave  (input bdir, input bc1, input data_in, output data_out, output data_oe);
endinterface

// File: rtl/psg_bus_control.sv
// rtl/psg_bus_control.sv - PSG bus front end: pin sync, mode glitch filter, LATCH/WRITE/READ decode
// Commits fire one cycle after the filtered mode leaves a LATCH or WRITE phase.
module psg_bus_control #(
  parameter int         SYNC_STAGES   = 2,
  parameter int         STABLE_CYCLES = 2,
  parameter logic [3:0] CHIP_ADDR     = 4'h0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  psg_bus_control_if.slave      bus,
  input  logic [7:0]            i_reg_rd_data,
  output logic [3:0]            o_reg_addr,
  output logic                  o_addr_valid,
  output logic                  o_reg_wr,
  output logic [7:0]            o_reg_wr_data
);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_READ  = 2'b01,
    MODE_WRITE = 2'b10,
    MODE_LATCH = 2'b11
  } mode_t;

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [SYNC_STAGES-1:0]      r_sync_bdir;
  logic [SYNC_STAGES-1:0]      r_sync_bc1;
  logic [SYNC_STAGES-1:0][7:0] r_sync_data;

  mode_t                       w_sync_mode;
  logic [7:0]                  w_sync_data;

  mode_t                       r_cand;
  logic [CNT_W-1:0]            r_run_cnt;
  logic [CNT_W-1:0]            w_run_len;
  logic                        w_accept;
  mode_t                       r_stable;

  logic [7:0]                  r_capture;
  logic                        w_capture_en;

  mode_t                       r_state;
  logic [3:0]                  r_reg_addr;
  logic                        r_addr_valid;
  logic                        r_reg_wr;
  logic [7:0]                  r_reg_wr_data;
  logic                        r_data_oe;
  logic [7:0]                  r_data_out;
  logic                        w_oe_next;

  // Data shares the control pins' depth so a captured byte belongs to the mode seen with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_bdir <= '0;
      r_sync_bc1  <= '0;
      r_sync_data <= '0;
    end else begin
      r_sync_bdir <= {r_sync_bdir[SYNC_STAGES-2:0], bus.bdir};
      r_sync_bc1  <= {r_sync_bc1[SYNC_STAGES-2:0], bus.bc1};
      r_sync_data <= {r_sync_data[SYNC_STAGES-2:0], bus.data_in};
    end
  end

  assign w_sync_mode = mode_t'({r_sync_bdir[SYNC_STAGES-1], r_sync_bc1[SYNC_STAGES-1]});
  assign w_sync_data = r_sync_data[SYNC_STAGES-1];

  // w_run_len counts cycles the current synchronized mode has held, saturating at the threshold.
  always_comb begin
    w_run_len = CNT_W'(1);
    if (w_sync_mode == r_cand) begin
      if (r_run_cnt == CNT_W'(STABLE_CYCLES)) begin
        w_run_len = r_run_cnt;
      end else begin
        w_run_len = r_run_cnt + 1'b1;
      end
    end
  end

  assign w_accept = (w_run_len == CNT_W'(STABLE_CYCLES));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cand    <= MODE_IDLE;
      r_run_cnt <= '0;
      r_stable  <= MODE_IDLE;
    end else begin
      r_cand    <= w_sync_mode;
      r_run_cnt <= w_run_len;
      if (w_accept) begin
        r_stable <= w_sync_mode;
      end
    end
  end

  assign w_capture_en = ((r_stable == MODE_WRITE) || (r_stable == MODE_LATCH)) &&
                        (w_sync_mode == r_stable);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_capture <= 8'h00;
    end else if (w_capture_en) begin
      r_capture <= w_sync_data;
    end
  end

  assign w_oe_next = (r_stable == MODE_READ) && r_addr_valid;

  // r_state trails r_stable by one cycle; a mismatch is the trailing edge of a phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= MODE_IDLE;
      r_reg_addr    <= 4'h0;
      r_addr_valid  <= 1'b0;
      r_reg_wr      <= 1'b0;
      r_reg_wr_data <= 8'h00;
      r_data_oe     <= 1'b0;
      r_data_out    <= 8'h00;
    end else begin
      r_reg_wr <= 1'b0;
      r_state  <= r_stable;
      case (r_state)
        MODE_LATCH: begin
          if (r_stable != MODE_LATCH) begin
            if (r_capture[7:4] == CHIP_ADDR) begin
              r_reg_addr   <= r_capture[3:0];
              r_addr_valid <= 1'b1;
            end else begin
              r_addr_valid <= 1'b0;
            end
          end
        end
        MODE_WRITE: begin
          if ((r_stable != MODE_WRITE) && r_addr_valid) begin
            r_reg_wr      <= 1'b1;
            r_reg_wr_data <= r_capture;
          end
        end
        default: begin
        end
      endcase
      r_data_oe  <= w_oe_next;
      r_data_out <= w_oe_next ? i_reg_rd_data : 8'h00;
    end
  end

  assign o_reg_addr    = r_reg_addr;
  assign o_addr_valid  = r_addr_valid;
  assign o_reg_wr      = r_reg_wr;
  assign o_reg_wr_data = r_reg_wr_data;
  assign bus.data_out  = r_data_out;
  assign bus.data_oe   = r_data_oe;

endmodule

// File: tb/tb_psg_bus_control.sv
// tb/tb_psg_bus_control.sv - randomized and directed bench for psg_bus_control against a window-based model
module tb_psg_bus_control;

  localparam int         S    = 2;
  localparam int         ST   = 2;
  localparam logic [3:0] CHIP = 4'h0;

  logic       clk;
  logic       rst_n;
  logic [7:0] rd_data;
  logic       rd_fixed;
  logic [3:0] reg_addr;
  logic       addr_valid;
  logic       reg_wr;
  logic [7:0] reg_wr_data;

  psg_bus_control_if bus ();

  psg_bus_control #(.SYNC_STAGES(S), .STABLE_CYCLES(ST), .CHIP_ADDR(CHIP)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .bus           (bus),
    .i_reg_rd_data (rd_data),
    .o_reg_addr    (reg_addr),
    .o_addr_valid  (addr_valid),
    .o_reg_wr      (reg_wr),
    .o_reg_wr_data (reg_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: sync is a pure delay line; stable_mode is whatever the last ST synced values agree on.
  logic [1:0] m_pipe_m [S];
  logic [7:0] m_pipe_d [S];
  logic [1:0] m_hist   [ST];
  logic [1:0] m_stable, m_prev;
  logic [7:0] m_cap, m_wr_data, m_dout;
  logic [3:0] m_addr;
  logic       m_av, m_wr, m_oe;

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      m_pipe_m[i] = 2'b00;
      m_pipe_d[i] = 8'h00;
    end
    for (int i = 0; i < ST; i++) m_hist[i] = 2'b00;
    m_stable = 2'b00; m_prev = 2'b00; m_cap = 8'h00; m_wr_data = 8'h00;
    m_dout = 8'h00; m_addr = 4'h0; m_av = 1'b0; m_wr = 1'b0; m_oe = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0] sm, st, pv;
    logic [7:0] sd, cap;
    logic       av, agree;
    sm = m_pipe_m[S-1]; sd = m_pipe_d[S-1];
    st = m_stable; pv = m_prev; av = m_av; cap = m_cap;
    for (int i = ST - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = sm;
    agree = 1'b1;
    for (int i = 1; i < ST; i++) if (m_hist[i] != m_hist[0]) agree = 1'b0;
    if (agree) m_stable = m_hist[0];
    if ((st == 2'b10 || st == 2'b11) && sm == st) m_cap = sd;
    if (pv == 2'b11 && st != 2'b11) begin
      if (cap[7:4] == CHIP) begin
        m_addr = cap[3:0];
        m_av   = 1'b1;
      end else begin
        m_av = 1'b0;
      end
    end
    m_wr = (pv == 2'b10) && (st != 2'b10) && av;
    if (m_wr) m_wr_data = cap;
    m_oe   = (st == 2'b01) && av;
    m_dout = m_oe ? rd_data : 8'h00;
    m_prev = st;
    for (int i = S - 1; i > 0; i--) begin
      m_pipe_m[i] = m_pipe_m[i-1];
      m_pipe_d[i] = m_pipe_d[i-1];
    end
    m_pipe_m[0] = {bus.bdir, bus.bc1};
    m_pipe_d[0] = bus.data_in;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  logic [11:0] wr_log [$];

  initial begin
    forever begin
      @(negedge clk);
      check("reg_addr",    reg_addr,     m_addr);
      check("addr_valid",  addr_valid,   m_av);
      check("reg_wr",      reg_wr,       m_wr);
      check("reg_wr_data", reg_wr_data,  m_wr_data);
      check("data_oe",     bus.data_oe,  m_oe);
      check("data_out",    bus.data_out, m_dout);
      if (reg_wr === 1'b1) wr_log.push_back({reg_addr, reg_wr_data});
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rd_fixed) rd_data = 8'($urandom);
    end
  end

  task automatic phase(input logic [1:0] m, input logic [7:0] d, input int n);
    bus.bdir    = m[1];
    bus.bc1     = m[0];
    bus.data_in = d;
    repeat (n) @(negedge clk);
  endtask

  int base;

  initial begin
    rst_n = 1'b0; rd_fixed = 1'b0; rd_data = 8'h00;
    bus.bdir = 1'b0; bus.bc1 = 1'b0; bus.data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_addr_valid", addr_valid, 1'b0);
    check("reset_data_oe", bus.data_oe, 1'b0);
    rst_n = 1'b1;
    phase(2'b00, 8'h00, 4);

    // LATCH 0x07 then WRITE 0xA5, strobe timing pinned by edge count
    base = wr_log.size();
    phase(2'b11, 8'h07, 6);
    phase(2'b10, 8'hA5, 6);
    bus.bdir = 1'b0; bus.bc1 = 1'b0; bus.data_in = 8'h00;
    repeat (4) @(posedge clk);
    #1 check("wr_before_edge5", reg_wr, 1'b0);
    @(posedge clk);
    #1 check("wr_at_edge5", reg_wr, 1'b1);
    check("wr_data_a5", reg_wr_data, 8'hA5);
    check("addr_7", reg_addr, 4'h7);
    check("av_1", addr_valid, 1'b1);
    @(posedge clk);
    #1 check("wr_falls", reg_wr, 1'b0);
    @(negedge clk);
    phase(2'b00, 8'h00, 4);
    check("one_strobe", wr_log.size() - base, 1);

    // foreign chip address deselects
    base = wr_log.size();
    phase(2'b11, 8'h17, 6);
    phase(2'b00, 8'h00, 4);
    phase(2'b10, 8'h55, 6);
    phase(2'b00, 8'h00, 6);
    check("deselect_av", addr_valid, 1'b0);
    check("deselect_addr", reg_addr, 4'h7);
    check("deselect_nowr", wr_log.size() - base, 0);

    // short WRITE pulse ignored, LATCH glitch inside WRITE ignored
    phase(2'b11, 8'h03, 6);
    phase(2'b00, 8'h00, 4);
    base = wr_log.size();
    phase(2'b10, 8'h66, 1);
    phase(2'b00, 8'h00, 6);
    check("short_pulse_nowr", wr_log.size() - base, 0);
    phase(2'b10, 8'h44, 3);
    phase(2'b11, 8'h99, 1);
    phase(2'b10, 8'h44, 3);
    phase(2'b00, 8'h00, 8);
    check("glitch_one_wr", wr_log.size() - base, 1);
    if (wr_log.size() > 0) check("glitch_entry", wr_log[$], {4'h3, 8'h44});
    check("glitch_addr", reg_addr, 4'h3);

    // READ drives the bus with the register-file data
    phase(2'b11, 8'h0E, 6);
    phase(2'b00, 8'h00, 4);
    rd_fixed = 1'b1; rd_data = 8'h3C;
    bus.bdir = 1'b0; bus.bc1 = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("oe_before_edge5", bus.data_oe, 1'b0);
    @(posedge clk);
    #1 check("oe_at_edge5", bus.data_oe, 1'b1);
    check("dout_3c", bus.data_out, 8'h3C);
    @(negedge clk);
    phase(2'b01, 8'h00, 3);
    bus.bdir = 1'b0; bus.bc1 = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("oe_hold_edge4", bus.data_oe, 1'b1);
    @(posedge clk);
    #1 check("oe_off_edge5", bus.data_oe, 1'b0);
    check("dout_zero", bus.data_out, 8'h00);
    @(negedge clk);
    rd_fixed = 1'b0;
    phase(2'b00, 8'h00, 4);

    // back-to-back minimum-length WRITE phases, then data changing with the mode
    phase(2'b11, 8'h02, 4);
    phase(2'b00, 8'h00, 4);
    base = wr_log.size();
    phase(2'b10, 8'h11, 4);
    phase(2'b00, 8'h00, 4);
    phase(2'b10, 8'h22, 4);
    phase(2'b00, 8'h00, 6);
    check("two_strobes", wr_log.size() - base, 2);
    if (wr_log.size() >= base + 2) begin
      check("strobe1", wr_log[base], {4'h2, 8'h11});
      check("strobe2", wr_log[base+1], {4'h2, 8'h22});
    end
    phase(2'b10, 8'h5A, 4);
    phase(2'b00, 8'hFF, 6);
    if (wr_log.size() > 0) check("coincident_edge", wr_log[$], {4'h2, 8'h5A});

    // async reset while stable_mode is WRITE drops the pending strobe
    phase(2'b11, 8'h01, 4);
    phase(2'b00, 8'h00, 4);
    phase(2'b10, 8'h77, 5);
    #2 rst_n = 1'b0;
    #1;
    check("rst_addr", reg_addr, 4'h0);
    check("rst_av", addr_valid, 1'b0);
    check("rst_wr", reg_wr, 1'b0);
    check("rst_wr_data", reg_wr_data, 8'h00);
    check("rst_oe", bus.data_oe, 1'b0);
    check("rst_dout", bus.data_out, 8'h00);
    bus.bdir = 1'b0; bus.bc1 = 1'b0; bus.data_in = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = wr_log.size();
    phase(2'b00, 8'h00, 12);
    check("rst_no_wr", wr_log.size() - base, 0);

    // randomized phases, checked cycle by cycle against the model
    for (int p = 0; p < 300; p++) begin
      logic [1:0] m;
      logic [7:0] d;
      int         len;
      m   = 2'($urandom_range(0, 3));
      d   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d[7:4] = 4'h0;
      len = $urandom_range(1, 6);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 4) == 0) d = 8'($urandom);
        phase(m, d, 1);
      end
      if ($urandom_range(0, 1) == 0) phase(2'b00, 8'($urandom), $urandom_range(1, 4));
    end
    phase(2'b00, 8'h00, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psg_bus_control.md
# psg_bus_control

Bus front end of the PSG. It samples the asynchronous BDIR/BC1 control pins and the 8-bit data bus, and filters glitches out of the bus mode. It then decodes the AY-3-8913 LATCH/WRITE/READ cycles into register-file strobes, which form the write path into the tone, noise, mixer and envelope registers. Commits happen on the trailing edge of each bus phase, detected from the filtered mode.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in each pin synchronizer (≥2)
- STABLE_CYCLES, 2, consecutive synchronized cycles a new mode must hold before it is accepted (≥1)
- CHIP_ADDR, 4'h0, required value of data[7:4] during LATCH for the chip to be selected

Ports:
- clk  in  1  system clock, all flops on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- bdir  in  1  bus direction pin, asynchronous
- bc1  in  1  bus control pin, asynchronous
- data_in  in  8  bus data pins, asynchronous
- reg_rd_data  in  8  register-file read data for reg_addr
- reg_addr  out  4  selected register
- addr_valid  out  1  last LATCH matched CHIP_ADDR
- reg_wr  out  1  one-cycle write strobe
- reg_wr_data  out  8  data for reg_wr
- data_out  out  8  read data driven to bus
- data_oe  out  1  bus output enable

## Operation
- Mode encoding {bdir,bc1}:
  - 00 INACTIVE
  - 01 READ
  - 10 WRITE
  - 11 LATCH
- Synchronization: bdir, bc1 and data_in each pass through SYNC_STAGES flops of equal depth, so data and mode stay aligned.
- Glitch filter:
  - stable_mode takes the synchronized mode once that value has held for STABLE_CYCLES consecutive cycles.
  - Shorter excursions are ignored and leave stable_mode unchanged.
- State machine: states IDLE/READ/WRITE/LATCH mirror stable_mode. Transitions between any pair are legal.
- Data capture:
  - A capture register loads the synchronized data every cycle while stable_mode ∈ {WRITE, LATCH} and the synchronized mode equals stable_mode.
  - It therefore holds the last bus data before the pins left the phase.
  - Data changing coincident with the mode pins is not captured.
- Leaving LATCH (prev = LATCH, current ≠ LATCH), next cycle:
  - If capture[7:4] == CHIP_ADDR: reg_addr ← capture[3:0], addr_valid ← 1.
  - Otherwise addr_valid ← 0 and reg_addr is unchanged.
- Leaving WRITE, next cycle:
  - If addr_valid = 1: reg_wr = 1 for exactly one cycle, with reg_wr_data ← capture.
  - If addr_valid = 0: no strobe.
- WRITE→LATCH direct: the write commits with the old address; the new address commits when LATCH is left.
- READ:
  - data_oe = 1 while stable_mode = READ and addr_valid = 1.
  - data_out is registered from reg_rd_data every cycle while data_oe = 1, and is 8'h00 otherwise.
- Repeated WRITE phases without a new LATCH each produce a strobe to the same reg_addr.
- Reset values, all asynchronous on rst_n = 0: every synchronizer, capture and history flop = 0; stable_mode = INACTIVE; reg_addr = 0; addr_valid = 0; reg_wr = 0; reg_wr_data = 0; data_out = 0; data_oe = 0.
- Reset mid-cycle: any pending strobe is dropped. After release, the first accepted mode produces no spurious leave-event, because the previous mode resets to INACTIVE.

## Timing
- Pins change before rising edge 1. The synchronized mode is visible after edge SYNC_STAGES.
- stable_mode updates on edge SYNC_STAGES+STABLE_CYCLES (edge 4 with defaults).
- reg_wr, and the reg_addr/addr_valid update, occur on edge SYNC_STAGES+STABLE_CYCLES+1 (edge 5). reg_wr falls on the following edge.
- data_oe rises on edge SYNC_STAGES+STABLE_CYCLES+1 after entering READ. data_out follows reg_rd_data with 1-cycle latency.
- Minimum accepted phase length is STABLE_CYCLES cycles. Minimum inactive gap between phases of the same mode is STABLE_CYCLES cycles.
- Throughput: at most one reg_wr per 2×STABLE_CYCLES cycles. Strobes are never merged or lost for phases meeting these minima.

## Test plan
- Reset: assert rst_n = 0 while stable_mode = WRITE → all outputs 0 immediately; release with pins 00 → no reg_wr ever.
- LATCH data 0x07 for 6 cycles, then WRITE data 0xA5 for 6 cycles, then 00 → addr_valid = 1, reg_addr = 7, and a single reg_wr with reg_wr_data = 0xA5 on edge 5 after WRITE exit.
- LATCH data 0x17 (CHIP_ADDR = 0), then WRITE 0x55 → addr_valid = 0, reg_addr unchanged, no reg_wr.
- After a valid LATCH 0x03, a 1-cycle WRITE pulse → no reg_wr. Also a 1-cycle 11 glitch during WRITE → exactly one reg_wr, address still 3.
- After LATCH 0x0E, READ with reg_rd_data = 0x3C → data_oe = 1 from edge 5, data_out = 0x3C; mode 00 → data_oe = 0 and data_out = 0x00 after 5 edges.
- LATCH 0x02, then WRITE 0x11 / 00 / WRITE 0x22, each phase 4 cycles → two reg_wr pulses to address 2 with data 0x11 then 0x22. Also WRITE changing data and mode on the same edge → captured data is the pre-change value.
